mux_n1_hs: RTL and testbench
============================

// Module: mux_n1_hs
// PURPOSE
//  Parametrised N-input, W-bit registered multiplexer with valid/ready handshake.
//  Generalises the single-bit 2:1 combinational mux to N channels and W-bit data.
//  Adds a 1-deep output register plus per-channel flow control.
//  Sits between N producer channels and one consumer (bus/datapath staging).
// PARAMETERS
//  N   4  number of input channels (2..16, need not be a power of 2)
//  W   8  data width per channel, bits
//  SW  2  select/channel-id width, ceil(log2(N)); SW >= 1
// PORTS
//  clk   in   1    clock, rising-edge
//  rst   in   1    asynchronous, active-high reset
//  d     in   N*W  channel data, channel k at d[k*W +: W]
//  vd    in   N    per-channel valid
//  rd    out  N    per-channel ready (accept strobe when vd[k]&rd[k])
//  s     in   SW   manual channel select
//  mode  in   1    0=manual select by s; 1=round-robin (only with RR_ARB_EN)
//  y     out  W    registered output data
//  vy    out  1    output valid
//  ry    in   1    downstream ready
//  yid   out  SW   channel index that produced current y
// BEHAVIOUR
//  - Reset (async, rst=1): y=0, vy=0, yid=0, ptr=0. rd=0 while rst is high.
//  - free = ~vy | ry  (output register can load this cycle).
//  - Grant g (combinational), manual mode: g=s, valid iff s<N and vd[s]=1.
//    s>=N -> no grant, rd=0 on all channels.
//  - rd[k] = free & grant_valid & (g==k). At most one rd bit is high (one-hot or 0).
//  - Transfer on channel k when vd[k]&rd[k]. At the next edge: y<=d[k], yid<=k, vy<=1.
//  - Latency: accept at edge t -> y/vy visible after edge t (1 cycle).
//  - Output hold: vy=1 & ry=0 -> y, yid and vy are held stable, and every rd stays 0.
//  - vy=1 & ry=1 & new grant -> back-to-back transfer; full throughput is 1/cycle.
//  - vy=1 & ry=1 & no grant -> vy<=0 at the next edge; y and yid keep their last value.
//  - Changing s while the output is held has no effect on y. The new s applies
//    at the next cycle where free=1.
//  - Producers must hold d/vd until their accept. The block does not check this.
//  - Reset mid-transfer drops the held word: vy=0 immediately. No accept occurs
//    in any cycle where rst=1.
// CONFIGURATION
//  Macro RR_ARB_EN:
//  - Defined: mode=1 enables round-robin.
//    g = first k with vd[k]=1, scanning ptr, ptr+1, ... modulo N.
//    On each accept, ptr <= (g+1) mod N; the wrap at N-1 goes to 0 for any N.
//    s is ignored in this mode. ptr is held when there is no accept.
//    mode=0 behaves as manual. Switching mode does not reset ptr.
//  - Undefined: the ptr logic is not built; mode is ignored; always manual.
// TESTING
//  1 Reset: rst=1 at an arbitrary time -> y=0, vy=0, yid=0, rd=0 in the same cycle.
//  2 Manual: N=4, W=8, d={8'h44,8'h33,8'h22,8'h11}, vd=4'hF, s=2, ry=1
//    -> rd=4'b0100; next cycle y=8'h33, yid=2, vy=1.
//  3 Backpressure: vy=1, ry=0 for 5 cycles, s toggles 0..3 -> y/yid constant, rd=0.
//    Then ry=1 -> transfer resumes from the current s.
//  4 Invalid select: N=3, s=3, vd=3'b111 -> rd=0.
//    vy drops to 0 one cycle after the held word is taken (ry=1).
//  5 RR (RR_ARB_EN, mode=1): vd=4'b1011, ry=1 held -> yid sequence 0,1,3,0,1,3.
//    With N=3, vd=3'b111 -> yid sequence 0,1,2,0 (wrap).
//  6 Reset mid-stream: in RR mode, assert rst while vy=1
//    -> vy=0 immediately; after release the first yid is the lowest valid channel.

Source files
------------

// File: rtl/mux_n1_hs.sv
// ---------------------------------------------------------------------------
// mux_n1_hs
//   N-input, W-bit registered multiplexer with valid/ready handshake on every
//   producer channel and on the single consumer side. A one-deep output
//   register holds the selected word together with the index of the channel
//   that produced it.
//
//   Optional feature: define RR_ARB_EN to build the round-robin arbiter
//   (selected at run time by mode=1). Without it, mode is ignored and the
//   channel is always chosen by s.
//
// Parameters
//   N   number of input channels (2..16, need not be a power of 2)
//   W   data width per channel
//   SW  channel-id width, ceil(log2(N)), at least 1
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   d     in   channel data, channel k at d[k*W +: W]
//   vd    in   per-channel valid
//   rd    out  per-channel ready (at most one bit high)
//   s     in   manual channel select
//   mode  in   0 = manual select, 1 = round-robin (RR_ARB_EN only)
//   y     out  registered output data
//   vy    out  output valid
//   ry    in   downstream ready
//   yid   out  channel index that produced y
// ---------------------------------------------------------------------------
module mux_n1_hs #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int SW = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  d,
   input  logic [N-1:0]    vd,
   output logic [N-1:0]    rd,
   input  logic [SW-1:0]   s,
   input  logic            mode,
   output logic [W-1:0]    y,
   output logic            vy,
   input  logic            ry,
   output logic [SW-1:0]   yid
);

   logic          free;
   logic          grant_valid;
   logic [SW-1:0] g;
   logic          accept;
   logic [W-1:0]  dsel;

   // Manual grant. The select is compared against every legal channel index
   // so an out-of-range s simply matches nothing and yields no grant.
   logic [SW-1:0] g_man;
   logic          gv_man;

   always_comb begin
      g_man  = s;
      gv_man = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (s == SW'(k)) gv_man = vd[k];
      end
   end

`ifdef RR_ARB_EN
   // Round-robin grant: first valid channel scanning ptr, ptr+1, ... mod N.
   logic [SW-1:0] ptr;
   logic [SW-1:0] g_rr;
   logic          gv_rr;
   int            idx;

   always_comb begin
      g_rr  = '0;
      gv_rr = 1'b0;
      idx   = 0;
      for (int off = 0; off < N; off++) begin
         idx = int'(ptr) + off;
         if (idx >= N) idx = idx - N;
         for (int k = 0; k < N; k++) begin
            if (!gv_rr && (idx == k) && vd[k]) begin
               gv_rr = 1'b1;
               g_rr  = SW'(k);
            end
         end
      end
   end

   assign g           = mode ? g_rr  : g_man;
   assign grant_valid = mode ? gv_rr : gv_man;

   // Pointer advances past the winner only on round-robin accepts; the
   // explicit wrap keeps it inside 0..N-1 for non power-of-2 N.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (accept && mode) begin
         ptr <= (g == SW'(N-1)) ? '0 : g + SW'(1);
      end
   end
`else
   logic unused_mode;
   assign unused_mode = mode;

   assign g           = g_man;
   assign grant_valid = gv_man;
`endif

   // Output register can take a new word when empty or being drained.
   assign free = ~vy | ry;

   // Ready is forced low during reset so no accept can happen while rst=1.
   for (genvar gi = 0; gi < N; gi++) begin : g_rd
      assign rd[gi] = ~rst & free & grant_valid & (g == SW'(gi));
   end

   assign accept = |(vd & rd);

   always_comb begin
      dsel = '0;
      for (int k = 0; k < N; k++) begin
         if (g == SW'(k)) dsel = d[k*W +: W];
      end
   end

   // Output stage: load on accept, drop valid when drained with no new word;
   // y and yid keep their last value when vy falls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y   <= '0;
         vy  <= 1'b0;
         yid <= '0;
      end else if (accept) begin
         y   <= dsel;
         yid <= g;
         vy  <= 1'b1;
      end else if (ry) begin
         vy  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_n1_hs.sv
module tb_mux_n1_hs;

   logic        clk;
   logic        rst;

   // N=4 instance
   logic [31:0] d4;
   logic [3:0]  vd4;
   logic [3:0]  rd4;
   logic [1:0]  s4;
   logic        mode4;
   logic [7:0]  y4;
   logic        vy4;
   logic        ry4;
   logic [1:0]  yid4;

   // N=3 instance
   logic [23:0] d3;
   logic [2:0]  vd3;
   logic [2:0]  rd3;
   logic [1:0]  s3;
   logic        mode3;
   logic [7:0]  y3;
   logic        vy3;
   logic        ry3;
   logic [1:0]  yid3;

   int errors = 0;
   int checks = 0;

   mux_n1_hs #(.N(4), .W(8), .SW(2)) dut4 (
      .clk(clk), .rst(rst), .d(d4), .vd(vd4), .rd(rd4), .s(s4),
      .mode(mode4), .y(y4), .vy(vy4), .ry(ry4), .yid(yid4)
   );

   mux_n1_hs #(.N(3), .W(8), .SW(2)) dut3 (
      .clk(clk), .rst(rst), .d(d3), .vd(vd3), .rd(rd3), .s(s3),
      .mode(mode3), .y(y3), .vy(vy3), .ry(ry3), .yid(yid3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef RR_ARB_EN
   int rr4_exp[6] = '{0, 1, 3, 0, 1, 3};
   int rr3_exp[4] = '{0, 1, 2, 0};
`endif

   initial begin
      rst = 1'b1;
      d4 = 32'h44332211; vd4 = 4'hF; s4 = 2'd2; mode4 = 1'b0; ry4 = 1'b1;
      d3 = 24'hC3B2A1;   vd3 = 3'b111; s3 = 2'd0; mode3 = 1'b0; ry3 = 1'b1;

      // Reset: outputs cleared and no ready while rst is high, even with valids
      tick();
      check("rst_y",   y4,   0);
      check("rst_vy",  vy4,  0);
      check("rst_yid", yid4, 0);
      check("rst_rd",  rd4,  0);
      check("rst_rd3", rd3,  0);
      vd3 = 3'b000;
      rst = 1'b0;
      #1;

      // Manual select s=2
      check("man_rd", rd4, 4'b0100);
      tick();
      check("man_y",   y4,   8'h33);
      check("man_yid", yid4, 2);
      check("man_vy",  vy4,  1);
      $display("txn manual s=2 y=%0h yid=%0d", y4, yid4);

      // Backpressure: hold for 5 cycles while s walks 0..3
      ry4 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s4 = 2'(i % 4);
         #1;
         check("bp_rd", rd4, 0);
         tick();
         check("bp_y",   y4,   8'h33);
         check("bp_yid", yid4, 2);
         check("bp_vy",  vy4,  1);
      end
      $display("txn backpressure held y=%0h yid=%0d", y4, yid4);

      // Release with s=1 -> transfer from the current select
      s4 = 2'd1; ry4 = 1'b1;
      #1;
      check("rel_rd", rd4, 4'b0010);
      tick();
      check("rel_y",   y4,   8'h22);
      check("rel_yid", yid4, 1);
      check("rel_vy",  vy4,  1);
      $display("txn release s=1 y=%0h yid=%0d", y4, yid4);

      // Back-to-back on the last channel
      s4 = 2'd3;
      #1;
      check("b2b_rd", rd4, 4'b1000);
      tick();
      check("b2b_y",   y4,   8'h44);
      check("b2b_yid", yid4, 3);
      $display("txn b2b s=3 y=%0h yid=%0d", y4, yid4);

      // Selected channel not valid -> no grant, output drains, y/yid kept
      vd4 = 4'b0100; s4 = 2'd1;
      #1;
      check("novd_rd", rd4, 0);
      tick();
      check("drain_vy",  vy4,  0);
      check("drain_y",   y4,   8'h44);
      check("drain_yid", yid4, 3);
      $display("txn drain vy=%0d y=%0h", vy4, y4);

      // Reset mid-transfer: load a word, hold it, then assert rst between edges
      vd4 = 4'hF; s4 = 2'd0;
      tick();
      check("pre_rst_y", y4, 8'h11);
      ry4 = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_vy",  vy4,  0);
      check("mid_rst_y",   y4,   0);
      check("mid_rst_yid", yid4, 0);
      ry4 = 1'b1;
      #1;
      check("mid_rst_rd", rd4, 0);
      tick();
      check("rst_no_accept_vy", vy4, 0);
      rst = 1'b0;
      vd4 = 4'h0;
      $display("txn reset mid-transfer vy=%0d", vy4);

      // N=3: last legal channel, then out-of-range select
      vd3 = 3'b111; s3 = 2'd2; ry3 = 1'b1;
      #1;
      check("n3_rd", rd3, 3'b100);
      tick();
      check("n3_y",   y3,   8'hC3);
      check("n3_yid", yid3, 2);
      check("n3_vy",  vy3,  1);
      s3 = 2'd3;
      #1;
      check("n3_inv_rd", rd3, 0);
      tick();
      check("n3_inv_vy",  vy3,  0);
      check("n3_inv_y",   y3,   8'hC3);
      check("n3_inv_rd2", rd3,  0);
      $display("txn n3 invalid select vy=%0d y=%0h", vy3, y3);
      vd3 = 3'b000;

`ifdef RR_ARB_EN
      // Round-robin N=4, vd=1011 -> 0,1,3,0,1,3 (s ignored)
      mode4 = 1'b1; vd4 = 4'b1011; s4 = 2'd2; ry4 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("rr4_yid", yid4, 32'(rr4_exp[i]));
         check("rr4_vy",  vy4,  1);
         $display("txn rr4 yid=%0d y=%0h", yid4, y4);
      end
      // Two more accepts (0,1) so the pointer sits at 2, then reset
      tick();
      tick();
      check("rr4_pre_yid", yid4, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rr_rst_vy", vy4, 0);
      tick();
      rst = 1'b0;
      tick();
      check("rr_rst_first_yid", yid4, 0);
      check("rr_rst_first_y",   y4,   8'h11);
      $display("txn rr after reset yid=%0d", yid4);
      vd4 = 4'h0;

      // Round-robin N=3 wrap: 0,1,2,0
      mode3 = 1'b1; vd3 = 3'b111; ry3 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rr3_yid", yid3, 32'(rr3_exp[i]));
         $display("txn rr3 yid=%0d y=%0h", yid3, y3);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
